// File: rtl/x2050_panel_exec.sv
// Operator-panel function executor for the 2050: one storage access, IC load,
// or step/repeat pulse per button press.
module x2050_panel_exec #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned AW      = 24
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [3:0]    i_oppanel,
  input  logic [AW-1:0] i_addr_sw,
  input  logic [31:0]   i_data_sw,
  input  logic          i_mem_ack,
  input  logic [31:0]   i_mem_rdata,
  output logic          o_mem_req,
  output logic          o_mem_we,
  output logic [1:0]    o_mem_sel,
  output logic [AW-1:0] o_mem_addr,
  output logic [31:0]   o_mem_wdata,
  output logic [31:0]   o_display,
  output logic [AW-1:0] o_ic,
  output logic          o_ic_load,
  output logic          o_step,
  output logic          o_repeat,
  output logic          o_busy,
  output logic          o_err
);

  typedef enum logic [1:0] {IDLE, SETUP, REQ, DONE} state_t;

  state_t        state, state_nxt;
  logic          arm;
  logic [3:0]    fn;
  logic [3:0]    last_fn;
  logic [AW-1:0] addr;
  logic [AW-1:0] addr_step;
  logic [7:0]    tcnt;
  logic          start;
  logic          timeout_hit;

  assign start       = (state == IDLE) && arm && (i_oppanel != 4'b0000);
  assign timeout_hit = (state == REQ) && !i_mem_ack && (tcnt == 8'(TIMEOUT - 1));
  assign o_mem_req   = (state == REQ);
  assign o_busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start && i_oppanel[3]) state_nxt = SETUP;
      SETUP: state_nxt = REQ;
      REQ: begin
        if (i_mem_ack)        state_nxt = DONE;
        else if (timeout_hit) state_nxt = IDLE;
      end
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    case (fn[2:1])
      2'b00:   addr_step = AW'(4);
      2'b01:   addr_step = AW'(2048);
      default: addr_step = AW'(1);
    endcase
  end

  // Address is held unmasked so auto-increment works in the target's own units.
  always_comb begin
    case (o_mem_sel)
      2'b01:   o_mem_addr = addr & ~AW'(2047);
      2'b10:   o_mem_addr = AW'(addr[5:0]);
      default: o_mem_addr = addr & ~AW'(3);
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= IDLE;
      arm         <= 1'b1;
      fn          <= '0;
      last_fn     <= '0;
      addr        <= '0;
      tcnt        <= '0;
      o_mem_we    <= 1'b0;
      o_mem_sel   <= '0;
      o_mem_wdata <= '0;
      o_display   <= '0;
      o_ic        <= '0;
      o_ic_load   <= 1'b0;
      o_step      <= 1'b0;
      o_repeat    <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      o_ic_load <= 1'b0;
      o_step    <= 1'b0;
      o_repeat  <= 1'b0;

      if (start) begin
        arm <= 1'b0;
        case (i_oppanel)
          4'b0001: begin
            o_step  <= 1'b1;
            last_fn <= '0;
          end
          4'b0010: begin
            o_ic      <= {i_addr_sw[AW-1:1], 1'b0};
            o_ic_load <= 1'b1;
            last_fn   <= '0;
          end
          4'b0011: begin
            o_repeat <= 1'b1;
            last_fn  <= '0;
          end
          default: if (i_oppanel[3]) fn <= i_oppanel;
        endcase
      end else if (i_oppanel == 4'b0000) begin
        arm <= 1'b1;
      end

      if (state == SETUP) begin
        addr        <= (fn == last_fn) ? addr + addr_step : i_addr_sw;
        last_fn     <= fn;
        o_mem_we    <= fn[0];
        o_mem_sel   <= fn[2:1];
        o_mem_wdata <= i_data_sw;
        tcnt        <= '0;
      end

      if (state == REQ) begin
        if (i_mem_ack) begin
          o_display <= fn[0] ? o_mem_wdata : i_mem_rdata;
          o_err     <= 1'b0;
        end else if (timeout_hit) begin
          o_err <= 1'b1;
        end else begin
          tcnt <= tcnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_x2050_panel_exec.sv
// Directed bench for x2050_panel_exec: store/display, auto-increment, timeout,
// IC load, step/repeat pulses, arming and mid-operation reset.
module tb_x2050_panel_exec;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [3:0]  i_oppanel;
  logic [23:0] i_addr_sw;
  logic [31:0] i_data_sw;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
  logic        o_mem_req, o_mem_we, o_ic_load, o_step, o_repeat, o_busy, o_err;
  logic [1:0]  o_mem_sel;
  logic [23:0] o_mem_addr, o_ic;
  logic [31:0] o_mem_wdata, o_display;

  int checks = 0;
  int failures = 0;
  int req_cycles = 0, req_rises = 0, ic_pulses = 0, step_pulses = 0, rep_pulses = 0;
  logic req_prev = 1'b0;

  logic [23:0] cap_addr;
  logic [31:0] cap_wdata;
  logic        cap_we;
  logic [1:0]  cap_sel;
  int          req_lat;

  x2050_panel_exec #(.TIMEOUT(255), .AW(24)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_oppanel(i_oppanel),
    .i_addr_sw(i_addr_sw), .i_data_sw(i_data_sw),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_sel(o_mem_sel),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_display(o_display),
    .o_ic(o_ic), .o_ic_load(o_ic_load), .o_step(o_step), .o_repeat(o_repeat),
    .o_busy(o_busy), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    if (o_mem_req) req_cycles++;
    if (o_mem_req && !req_prev) req_rises++;
    req_prev = o_mem_req;
    if (o_ic_load) ic_pulses++;
    if (o_step) step_pulses++;
    if (o_repeat) rep_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // One store/display press; ack_at < 0 means never acknowledge.
  task automatic press_sd(input logic [3:0] code, input logic [23:0] a,
                          input logic [31:0] d, input int ack_at,
                          input logic [31:0] rdata, input int hold);
    int n;
    i_oppanel = code;
    i_addr_sw = a;
    i_data_sw = d;
    n = 0;
    while (!o_mem_req && n < 10) begin tick(); n++; end
    req_lat = n;
    if (!o_mem_req) check("req_seen", 32'(o_mem_req), 32'd1);
    cap_addr  = o_mem_addr;
    cap_wdata = o_mem_wdata;
    cap_we    = o_mem_we;
    cap_sel   = o_mem_sel;
    if (ack_at >= 0) begin
      tick(ack_at);
      i_mem_ack   = 1'b1;
      i_mem_rdata = rdata;
      tick();
      i_mem_ack   = 1'b0;
      i_mem_rdata = '0;
    end else begin
      n = 0;
      while (o_mem_req && n < 300) begin tick(); n++; end
      if (o_mem_req) check("timeout_bound", 32'(o_mem_req), 32'd0);
    end
    tick(hold);
    i_oppanel = 4'b0000;
    tick(2);
  endtask

  task automatic press_fn(input logic [3:0] code, input logic [23:0] a);
    i_oppanel = code;
    i_addr_sw = a;
    tick(3);
    i_oppanel = 4'b0000;
    tick(2);
  endtask

  initial begin
    int b_req, b_rise, b_step, b_ic, b_rep;
    i_reset = 1'b1; i_oppanel = '0; i_addr_sw = '0; i_data_sw = '0;
    i_mem_ack = 1'b0; i_mem_rdata = '0;
    tick(3);
    i_reset = 1'b0;
    tick();
    check("rst_req", 32'(o_mem_req), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_display", o_display, 32'd0);
    check("rst_ic", 32'(o_ic), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);

    // Display main store, ack after two REQ cycles, code held afterwards
    b_rise = req_rises;
    press_sd(4'b1000, 24'h000104, 32'h0, 2, 32'hDEADBEEF, 6);
    check("t1_addr", 32'(cap_addr), 32'h000104);
    check("t1_we", 32'(cap_we), 32'd0);
    check("t1_sel", 32'(cap_sel), 32'd0);
    check("t1_display", o_display, 32'hDEADBEEF);
    check("t1_single_req", 32'(req_rises - b_rise), 32'd1);

    // Fresh reset so the first display reloads from the switches
    i_reset = 1'b1; tick(); i_reset = 1'b0; tick();
    press_sd(4'b1000, 24'h000100, 32'h0, 0, 32'h11111111, 0);
    check("t2_addr0", 32'(cap_addr), 32'h000100);
    press_sd(4'b1000, 24'h000100, 32'h0, 0, 32'h22222222, 0);
    check("t2_addr1", 32'(cap_addr), 32'h000104);
    press_sd(4'b1000, 24'h000100, 32'h0, 1, 32'h33333333, 0);
    check("t2_addr2", 32'(cap_addr), 32'h000108);
    check("t2_display", o_display, 32'h33333333);
    press_sd(4'b1100, 24'h000100, 32'h0, 0, 32'h44444444, 0);
    check("t2_local_addr", 32'(cap_addr), 32'h000000);
    check("t2_local_sel", 32'(cap_sel), 32'd2);

    // Store main with latency check
    press_sd(4'b1001, 24'h000203, 32'h12345678, 0, 32'hCAFEF00D, 0);
    check("t3_latency", 32'(req_lat), 32'd2);
    check("t3_we", 32'(cap_we), 32'd1);
    check("t3_addr", 32'(cap_addr), 32'h000200);
    check("t3_wdata", cap_wdata, 32'h12345678);
    check("t3_display", o_display, 32'h12345678);

    // Timeout on protect-tag display
    b_req = req_cycles;
    press_sd(4'b1010, 24'h000FFF, 32'h0, -1, 32'h0, 0);
    check("t4_req_cycles", 32'(req_cycles - b_req), 32'd255);
    check("t4_err", 32'(o_err), 32'd1);
    check("t4_busy", 32'(o_busy), 32'd0);
    check("t4_display_kept", o_display, 32'h12345678);
    check("t4_prot_addr", 32'(cap_addr), 32'h000800);
    press_sd(4'b1000, 24'h000010, 32'h0, 0, 32'h0BADC0DE, 0);
    check("t4_err_clear", 32'(o_err), 32'd0);
    check("t4_display", o_display, 32'h0BADC0DE);

    // Set IC, step, repeat, reserved code and arming
    b_ic = ic_pulses; b_step = step_pulses; b_rep = rep_pulses; b_req = req_cycles;
    press_fn(4'b0010, 24'h000ABD);
    check("t5_ic", 32'(o_ic), 32'h000ABC);
    check("t5_ic_pulses", 32'(ic_pulses - b_ic), 32'd1);
    press_fn(4'b0001, 24'h0);
    check("t5_step_pulses", 32'(step_pulses - b_step), 32'd1);
    press_fn(4'b0011, 24'h0);
    check("t5_rep_pulses", 32'(rep_pulses - b_rep), 32'd1);
    b_step = step_pulses;
    i_oppanel = 4'b0110; tick(3);
    i_oppanel = 4'b0001; tick(3);
    check("t5_no_rearm_step", 32'(step_pulses - b_step), 32'd0);
    check("t5_reserved_busy", 32'(o_busy), 32'd0);
    press_fn(4'b0000, 24'h0);
    press_fn(4'b0001, 24'h0);
    check("t5_rearm_step", 32'(step_pulses - b_step), 32'd1);
    check("t5_no_req", 32'(req_cycles - b_req), 32'd0);

    // Reset during REQ; a late ack must not reach the display
    i_oppanel = 4'b1000; i_addr_sw = 24'h000040;
    tick(2);
    check("t6_in_req", 32'(o_mem_req), 32'd1);
    i_reset = 1'b1; i_oppanel = 4'b0000;
    tick();
    i_reset = 1'b0;
    check("t6_req_low", 32'(o_mem_req), 32'd0);
    check("t6_busy_low", 32'(o_busy), 32'd0);
    i_mem_ack = 1'b1; i_mem_rdata = 32'hFFFF0000;
    tick();
    i_mem_ack = 1'b0;
    tick();
    check("t6_display", o_display, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/x2050_panel_exec.md
Name: x2050_panel_exec

Overview:
- Executes the 4-bit operator-panel function code produced by the 2050 supervisory controls.
- Decodes the code and, for store/display, runs one storage access per button press on a request/acknowledge storage port. Target is main store, protect tags, local store or MPX bump.
- Also loads the instruction counter (set IC) and issues single-pulse step/repeat requests to the ROS sequencer.
- Sits between the supervisory block and the storage/local-store arbiters.

Parameters:
- TIMEOUT, 255, cycles to wait for i_mem_ack before aborting (8-bit counter; must be 1..255).
- AW, 24, storage address width.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset
- i_oppanel  in  4  panel function code: 0000 nil, 0001 insn step, 0010 set IC, 0011 repeat insn, 010x addr sync, 011x enter channel, 1yyz store/display (yy 00 main, 01 protect tags, 10 local, 11 bump; z 1 store, 0 display)
- i_addr_sw  in  AW  address switches
- i_data_sw  in  32  data switches
- i_mem_ack  in  1  storage acknowledge, one-cycle pulse
- i_mem_rdata  in  32  read data, valid with i_mem_ack
- o_mem_req  out  1  storage request
- o_mem_we  out  1  1 = write
- o_mem_sel  out  2  storage select (= yy)
- o_mem_addr  out  AW  storage address
- o_mem_wdata  out  32  write data
- o_display  out  32  display register
- o_ic  out  AW  instruction counter load value
- o_ic_load  out  1  one-cycle pulse, load o_ic
- o_step  out  1  one-cycle pulse, instruction step
- o_repeat  out  1  one-cycle pulse, repeat instruction
- o_busy  out  1  FSM not IDLE/ARMWAIT
- o_err  out  1  sticky storage timeout flag

Behaviour:
- Clock i_clk; reset i_reset, synchronous, active-high.
- Reset values: all outputs 0; state IDLE; arm=1; last_fn=0000; addr register 0; timeout count 0.
- Arming (one action per press):
  - An action starts only in IDLE with arm=1 and i_oppanel != 0000.
  - Starting clears arm.
  - arm sets again only after i_oppanel has been 0000 for one full cycle.
  - Codes 010x/011x: reserved; they clear arm and cause no action.
- Function timing, from the start cycle:
  - 0010: next cycle o_ic = i_addr_sw with bit0 forced 0; o_ic_load=1 for 1 cycle.
  - 0001: o_step=1 for 1 cycle, next cycle.
  - 0011: o_repeat=1 for 1 cycle, next cycle.
- Store/display FSM: IDLE -> SETUP -> REQ -> DONE -> IDLE.
  - SETUP (1 cycle):
    - If code == last_fn, addr += step; otherwise addr = i_addr_sw.
    - last_fn = code.
    - Step: main 4, protect 2048, local 1, bump 1.
    - Address wraps modulo 2^AW.
  - REQ: o_mem_req=1 with stable o_mem_we=z, o_mem_sel=yy, o_mem_addr (masked, see below), o_mem_wdata=i_data_sw latched in SETUP. Timeout counter cleared on entry.
  - On i_mem_ack in REQ:
    - Display: o_display <= i_mem_rdata.
    - Store: o_display <= written data.
    - o_mem_req drops the following cycle (DONE).
  - Ack in the same cycle REQ is entered is valid.
  - Ack while not in REQ is ignored.
  - DONE (1 cycle) -> IDLE.
- Address masking on o_mem_addr:
  - main/bump: low 2 bits forced 0.
  - local: only bits [5:0] kept, others 0.
  - protect: bits [10:0] forced 0.
- Latency:
  - With ack at the first REQ cycle, o_display updates 3 cycles after the start cycle.
  - o_busy is high SETUP..DONE inclusive.
- Timeout:
  - TIMEOUT REQ cycles without ack -> o_err=1, o_mem_req=0, state IDLE, o_display unchanged.
  - o_err is cleared only by i_reset or by the next successful ack.
- last_fn:
  - Non-store/display actions reset last_fn to 0000, so the next display reloads from the switches.
  - The 0000 gap between presses does not reset last_fn.
- Code changing mid-operation: ignored; operation parameters are latched at SETUP.
- i_reset mid-operation: immediate return to reset values; o_mem_req low the next cycle.

Test Plan:
- Reset, then hold code 1000 with addr_sw=0x000104, ack after 2 REQ cycles, rdata=0xDEADBEEF -> single o_mem_req, addr 0x000104, we=0, o_display=0xDEADBEEF. Holding the code produces no second request.
- Press 1000 three times (0000 between) with addr_sw=0x000100 -> addresses 0x100, 0x104, 0x108. Then 1100 press -> reload from switches, local addr 0x000000 (masked).
- Code 1001 with data_sw=0x12345678, addr_sw=0x000203 -> we=1, addr 0x000200, wdata 0x12345678, o_display=0x12345678 after ack.
- Code 1010 with no ack, TIMEOUT=255 -> o_mem_req high exactly 255 cycles, then o_err=1, busy=0. A next successful display clears o_err.
- Code 0010 with addr_sw=0x000ABD -> o_ic=0x000ABC, o_ic_load one pulse. Code 0001 -> one o_step pulse. Code 0110 -> no outputs, rearm only after 0000.
- Assert i_reset during REQ -> o_mem_req=0, o_busy=0 the next cycle. A later ack has no effect on o_display.
